// File: rtl/slave_bfm.sv
// Slave bus functional model: single-outstanding-transfer memory slave with
// configurable wait states, abort-on-drop and a one-cycle turnaround.
module slave_bfm #(
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rstz,
   input  logic        trans,
   input  logic        write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, WAIT, RESP, TURN} state_t;

   state_t          state_q;
   logic [3:0]      waitCnt_q;
   logic [AW-1:0]   wordIdx_q;
   logic            isWrite_q;
   logic [31:0]     wrData_q;
   logic            ready_q;
   logic [31:0]     rdata_q;
   logic [31:0]     mem_q [DEPTH];

   // Bits outside the word index alias onto the same word.
   logic unusedAddr;
   assign unusedAddr = ^{addr[31:AW+2], addr[1:0]};

   // Outputs are registered from the state, so ready/rdata appear the cycle after RESP.
   always_ff @(posedge clk) begin
      if (rstz) begin
         state_q   <= IDLE;
         waitCnt_q <= 4'd0;
         wordIdx_q <= '0;
         isWrite_q <= 1'b0;
         wrData_q  <= 32'd0;
         ready_q   <= 1'b0;
         rdata_q   <= 32'd0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
      end else begin
         ready_q <= 1'b0;
         rdata_q <= 32'd0;
         case (state_q)
            IDLE: begin
               if (trans) begin
                  isWrite_q <= write;
                  wordIdx_q <= addr[AW+1:2];
                  wrData_q  <= wdata;
                  waitCnt_q <= WAIT_LOAD;
                  state_q   <= (WAIT_CYCLES > 0) ? WAIT : RESP;
               end
            end
            WAIT: begin
               if (!trans) begin
                  state_q <= IDLE;
               end else if (waitCnt_q == 4'd0) begin
                  state_q <= RESP;
               end else begin
                  waitCnt_q <= waitCnt_q - 4'd1;
               end
            end
            RESP: begin
               ready_q <= 1'b1;
               if (isWrite_q) mem_q[wordIdx_q] <= wrData_q;
               else           rdata_q          <= mem_q[wordIdx_q];
               state_q <= TURN;
            end
            TURN:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ready = ready_q;
   assign rdata = rdata_q;

endmodule

// File: tb/tb_slave_bfm.sv
// Scoreboard bench for slave_bfm: expected read data is queued when a transfer
// is issued and popped whenever the slave strobes ready.
module tb_slave_bfm;

   localparam int W = 1;

   logic        clk = 1'b0;
   logic        rstz = 1'b1;
   logic        trans = 1'b0, write = 1'b0;
   logic [31:0] addr = '0, wdata = '0;
   logic [31:0] rdata;
   logic        ready;

   logic        transB = 1'b0, writeB = 1'b0;
   logic [31:0] addrB = '0, wdataB = '0;
   logic [31:0] rdataB;
   logic        readyB;

   int checks = 0;
   int errors = 0;
   logic [31:0] expQ [$];
   logic [31:0] model [256];

   slave_bfm #(.DEPTH(256), .WAIT_CYCLES(W)) dut (
      .clk(clk), .rstz(rstz), .trans(trans), .write(write),
      .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready));

   slave_bfm #(.DEPTH(256), .WAIT_CYCLES(0)) dutB (
      .clk(clk), .rstz(rstz), .trans(transB), .write(writeB),
      .addr(addrB), .wdata(wdataB), .rdata(rdataB), .ready(readyB));

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Every ready strobe must match the oldest queued expectation; otherwise rdata stays 0.
   always @(negedge clk) begin
      if (!rstz) begin
         if (ready) begin
            if (expQ.size() == 0) checkOutput("spuriousReady", {31'd0, ready}, 32'd0);
            else                  checkOutput("rdata", rdata, expQ.pop_front());
         end else begin
            checkOutput("rdataIdle", rdata, 32'd0);
         end
      end
   end

   // Issues one transfer, checks its latency and pulse width, and returns with the slave idle.
   task automatic applyStimulus(input logic wr, input logic [31:0] a, input logic [31:0] d);
      int  cyc;
      bit  seen;
      @(negedge clk);
      trans = 1'b1; write = wr; addr = a; wdata = d;
      expQ.push_back(wr ? 32'd0 : model[a[9:2]]);
      if (wr) model[a[9:2]] = d;
      @(posedge clk);
      cyc = 0; seen = 0;
      while (!seen && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
         if (ready) seen = 1;
      end
      checkOutput("latency", cyc, 1 + W);
      trans = 1'b0;
      @(posedge clk); #1;
      checkOutput("readyPulse", {31'd0, ready}, 32'd0);
   endtask

   initial begin
      int nReady, first, second;
      for (int i = 0; i < 256; i++) model[i] = 32'd0;

      // Reset held with a pending request: nothing may happen.
      trans = 1'b1; addr = 32'h10;
      repeat (3) begin
         @(posedge clk); #1;
         checkOutput("rstReady", {31'd0, ready}, 32'd0);
         checkOutput("rstRdata", rdata, 32'd0);
      end
      @(negedge clk); rstz = 1'b0; trans = 1'b0;

      applyStimulus(1'b0, 32'h0000_0010, 32'h0);
      applyStimulus(1'b1, 32'h0000_0004, 32'hDEAD_BEEF);
      applyStimulus(1'b0, 32'h0000_0004, 32'h0);
      applyStimulus(1'b1, 32'h0000_0008, 32'h1234_5678);
      applyStimulus(1'b0, 32'h0000_0408, 32'h0);
      applyStimulus(1'b0, 32'h0000_000B, 32'h0);
      applyStimulus(1'b0, 32'hFFFF_FC04, 32'h0);

      // Abort by dropping trans while waiting.
      @(negedge clk);
      trans = 1'b1; write = 1'b1; addr = 32'h20; wdata = 32'hAA;
      @(posedge clk);
      @(negedge clk); trans = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         checkOutput("abortReady", {31'd0, ready}, 32'd0);
      end
      applyStimulus(1'b0, 32'h0000_0020, 32'h0);

      // trans held across two transfers: two strobes only, W+3 apart.
      @(negedge clk);
      trans = 1'b1; write = 1'b0; addr = 32'h4;
      expQ.push_back(model[1]);
      expQ.push_back(model[2]);
      @(posedge clk);
      @(negedge clk); addr = 32'h8;
      nReady = 0; first = 0; second = 0;
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk); #1;
         if (ready) begin
            nReady++;
            if (nReady == 1) first = k;
            else             second = k;
            if (nReady >= 2) trans = 1'b0;
         end
      end
      trans = 1'b0;
      checkOutput("b2bCount", nReady, 2);
      checkOutput("b2bFirst", first, 1 + W);
      checkOutput("b2bSpacing", second - first, W + 3);

      // Reset during the wait of a write: no ready, no write, memory cleared.
      @(negedge clk);
      trans = 1'b1; write = 1'b1; addr = 32'h30; wdata = 32'h55;
      @(posedge clk);
      @(negedge clk); rstz = 1'b1; trans = 1'b0;
      @(posedge clk); #1;
      checkOutput("midRstReady", {31'd0, ready}, 32'd0);
      @(negedge clk); rstz = 1'b0;
      for (int i = 0; i < 256; i++) model[i] = 32'd0;
      repeat (3) begin
         @(posedge clk); #1;
         checkOutput("postRstReady", {31'd0, ready}, 32'd0);
      end
      applyStimulus(1'b0, 32'h0000_0030, 32'h0);
      applyStimulus(1'b0, 32'h0000_0004, 32'h0);

      // Zero-wait build: ready follows the accepting edge by one cycle.
      @(negedge clk);
      transB = 1'b1; writeB = 1'b1; addrB = 32'h40; wdataB = 32'hCAFE_F00D;
      @(posedge clk); #1;
      checkOutput("bEarly", {31'd0, readyB}, 32'd0);
      @(posedge clk); #1;
      checkOutput("bWrReady", {31'd0, readyB}, 32'd1);
      transB = 1'b0;
      @(posedge clk); #1;
      checkOutput("bPulse", {31'd0, readyB}, 32'd0);
      @(negedge clk);
      transB = 1'b1; writeB = 1'b0; addrB = 32'h40;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("bRdReady", {31'd0, readyB}, 32'd1);
      checkOutput("bRdata", rdataB, 32'hCAFE_F00D);
      transB = 1'b0;
      @(posedge clk); #1;
      checkOutput("bRdataAfter", rdataB, 32'd0);

      repeat (3) @(posedge clk);
      checkOutput("sbEmpty", expQ.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
